// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU with registered result and flags, plus a
// WIDTH-cycle shift-add multiplier sequenced by a two-state FSM.

// Assertion checker for the output handshake and the busy phase.
module alu_pipe_chk #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  input logic             busy,
  input logic             in_ready,
  input logic             out_valid,
  input logic             out_ready,
  input logic [WIDTH-1:0] result,
  input logic             flag_z,
  input logic             flag_n,
  input logic             flag_c,
  input logic             flag_v,
  input logic             err
);

  hold_a: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(result) && $stable(err)));

  busy_a: assert property (@(posedge clk) disable iff (rst)
    busy |-> (!in_ready && !out_valid));

  err_a: assert property (@(posedge clk) disable iff (rst)
    err |-> ((result == {WIDTH{1'b0}}) && flag_z && !flag_n && !flag_c && !flag_v));

endmodule

module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               accept_s;
  logic               mul_start_s;
  logic               alu_load_s;
  logic               mul_done_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic               alu_c_s;
  logic               alu_v_s;
  logic               alu_err_s;
  logic [2*WIDTH-1:0] mcand_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   mplier_r;
  logic [SHW-1:0]     cnt_r;
  logic [WIDTH-1:0]   result_r;
  logic               out_valid_r;
  logic               z_r;
  logic               n_r;
  logic               c_r;
  logic               v_r;
  logic               err_r;

  assign in_ready    = (state_r == IDLE) && (!out_valid_r || out_ready);
  assign accept_s    = in_valid && in_ready;
  assign mul_start_s = accept_s && (op == OP_MUL);
  assign alu_load_s  = accept_s && (op != OP_MUL);
  assign mul_done_s  = (state_r == BUSY) && (cnt_r == LAST_ITER);

  assign sum_s  = {1'b0, a} + {1'b0, b};
  assign diff_s = {1'b0, a} - {1'b0, b};
  // Accumulator value after folding in the current multiplier bit.
  assign prod_s = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign flag_z    = z_r;
  assign flag_n    = n_r;
  assign flag_c    = c_r;
  assign flag_v    = v_r;
  assign err       = err_r;

  // Single-cycle operation datapath and carry/overflow generation.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    alu_err_s = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res_s = sum_s[WIDTH-1:0];
        alu_c_s   = sum_s[WIDTH];
        alu_v_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = diff_s[WIDTH-1:0];
        alu_c_s   = diff_s[WIDTH];
        alu_v_s   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res_s = a & b;
      OP_OR:   alu_res_s = a | b;
      OP_XOR:  alu_res_s = a ^ b;
      OP_SHL:  alu_res_s = a << b[SHW-1:0];
      OP_SHR:  alu_res_s = a >> b[SHW-1:0];
      OP_NOT:  alu_res_s = ~a;
      OP_SRA:  alu_res_s = $signed(a) >>> b[SHW-1:0];
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MUL:  alu_res_s = {WIDTH{1'b0}};
      default: alu_err_s = 1'b1;
    endcase
  end

  // Multiplier sequencing: IDLE accepts, BUSY runs WIDTH iterations.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (mul_start_s) state_nxt_s = BUSY;
        else             state_nxt_s = IDLE;
      end
      BUSY: begin
        if (mul_done_s) state_nxt_s = IDLE;
        else            state_nxt_s = BUSY;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Shift-add multiplier registers; operands latched at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r  <= {(2*WIDTH){1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {SHW{1'b0}};
    end else if (mul_start_s) begin
      mcand_r  <= {{WIDTH{1'b0}}, a};
      acc_r    <= {(2*WIDTH){1'b0}};
      mplier_r <= b;
      cnt_r    <= {SHW{1'b0}};
    end else if (state_r == BUSY) begin
      acc_r    <= prod_s;
      mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      cnt_r    <= cnt_r + SHW'(1);
    end else begin
      cnt_r    <= cnt_r;
    end
  end

  // Output register: load on single-cycle accept or MUL completion, clear on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      z_r         <= 1'b0;
      n_r         <= 1'b0;
      c_r         <= 1'b0;
      v_r         <= 1'b0;
      err_r       <= 1'b0;
    end else if (alu_load_s) begin
      out_valid_r <= 1'b1;
      result_r    <= alu_res_s;
      z_r         <= (alu_res_s == {WIDTH{1'b0}});
      n_r         <= alu_res_s[WIDTH-1];
      c_r         <= alu_c_s;
      v_r         <= alu_v_s;
      err_r       <= alu_err_s;
    end else if (mul_done_s) begin
      out_valid_r <= 1'b1;
      result_r    <= prod_s[WIDTH-1:0];
      z_r         <= (prod_s[WIDTH-1:0] == {WIDTH{1'b0}});
      n_r         <= prod_s[WIDTH-1];
      c_r         <= |prod_s[2*WIDTH-1:WIDTH];
      v_r         <= 1'b0;
      err_r       <= 1'b0;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  alu_pipe_chk #(.WIDTH(WIDTH)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .busy      (state_r == BUSY),
    .in_ready  (in_ready),
    .out_valid (out_valid_r),
    .out_ready (out_ready),
    .result    (result_r),
    .flag_z    (z_r),
    .flag_n    (n_r),
    .flag_c    (c_r),
    .flag_v    (v_r),
    .err       (err_r)
  );

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: table vectors and random ops through a scoreboard,
// plus hand sequences for MUL latency, output stall and reset abort.
module tb_alu_pipe;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
    logic       e;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       flag_z, flag_n, flag_c, flag_v, err;

  int   total = 0;
  int   bad = 0;
  int   rx_count = 0;
  int   stalls = 0;
  logic rnd_mode = 1'b0;
  vec_t scb[$];
  vec_t tbl[20];

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .flag_v(flag_v), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model, written in integer arithmetic.
  function automatic vec_t model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    vec_t r;
    int sx, sy, ux, uy, s;
    sx = $signed(x); sy = $signed(y); ux = x; uy = y;
    r.op = o; r.a = x; r.b = y; r.res = 8'h00;
    r.c = 1'b0; r.v = 1'b0; r.e = 1'b0;
    case (o)
      4'd0: begin s = ux + uy; r.res = s[7:0]; r.c = (s > 255);
              r.v = ((sx + sy) > 127) || ((sx + sy) < -128); end
      4'd1: begin s = ux - uy; r.res = s[7:0]; r.c = (ux < uy);
              r.v = ((sx - sy) > 127) || ((sx - sy) < -128); end
      4'd2: r.res = x & y;
      4'd3: r.res = x | y;
      4'd4: r.res = x ^ y;
      4'd5: r.res = x << y[2:0];
      4'd6: r.res = x >> y[2:0];
      4'd7: r.res = ~x;
      4'd8: begin s = sx >>> y[2:0]; r.res = s[7:0]; end
      4'd9: r.res = (sx < sy) ? 8'd1 : 8'd0;
      4'd10: r.res = (ux < uy) ? 8'd1 : 8'd0;
      4'd11: begin s = ux * uy; r.res = s[7:0]; r.c = (s > 255); end
      default: r.e = 1'b1;
    endcase
    r.z = (r.res == 8'h00);
    r.n = r.res[7];
    return r;
  endfunction

  // Drive one op; push its expectation when the DUT is seen ready.
  task automatic send(input vec_t v);
    logic ok;
    ok = 1'b0;
    op = v.op; a = v.a; b = v.b; in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      stalls++;
      @(posedge clk); #1;
      if (rnd_mode) out_ready = 1'b1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: op %0d never accepted, expected acceptance", v.op);
      in_valid = 1'b0;
    end else begin
      scb.push_back(v);
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (scb.size() == 0) break;
    end
    chk("drain_empty", scb.size(), 0);
    @(posedge clk); #1;
  endtask

  // Output monitor: every transfer is compared against the scoreboard head.
  always @(negedge clk) begin
    vec_t e;
    if (!rst && out_valid && out_ready) begin
      total++;
      if (scb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got result %0h, expected no output", result);
      end else begin
        e = scb.pop_front();
        rx_count++;
        if ({result, flag_z, flag_n, flag_c, flag_v, err} !== {e.res, e.z, e.n, e.c, e.v, e.e}) begin
          bad++;
          $display("FAIL result op=%0d a=%0h b=%0h: got res=%0h znvce=%b%b%b%b%b expected res=%0h znvce=%b%b%b%b%b",
                   e.op, e.a, e.b, result, flag_z, flag_n, flag_c, flag_v, err,
                   e.res, e.z, e.n, e.c, e.v, e.e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   rx0, st0, first, busy_bad, ov_cnt;
    vec_t v;

    //           op     a      b      res    z     n     c     v     e
    tbl[0]  = '{4'd0,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{4'd1,  8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{4'd1,  8'h01, 8'h02, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{4'd0,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{4'd2,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{4'd3,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{4'd4,  8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{4'd5,  8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{4'd6,  8'h81, 8'h03, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{4'd7,  8'h0F, 8'h00, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{4'd8,  8'h90, 8'h02, 8'hE4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{4'd9,  8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{4'd10, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{4'd12, 8'h55, 8'h66, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{4'd15, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{4'd5,  8'h01, 8'h0B, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{4'd1,  8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{4'd11, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{4'd11, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{4'd9,  8'h01, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'd0; a = 8'h00; b = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {flag_z, flag_n, flag_c, flag_v}, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(tbl[i]);
    drain();

    // MUL latency and busy back-pressure; inputs scrambled after acceptance.
    send('{4'd11, 8'd13, 8'd11, 8'h8F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    in_valid = 1'b0; op = 4'd0; a = 8'hFF; b = 8'hFF;
    first = -1; busy_bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c < 8 && in_ready) busy_bad++;
      if (out_valid) begin first = c; break; end
    end
    chk("mul_latency", first, 8);
    chk("mul_busy_in_ready", busy_bad, 0);
    drain();

    // Back-to-back ADDs at full throughput.
    rx0 = rx_count; st0 = stalls;
    for (int i = 0; i < 4; i++) send(model(4'd0, 8'(i * 17), 8'(i + 3)));
    in_valid = 1'b0;
    @(negedge clk); #1;
    chk("b2b_results", rx_count - rx0, 4);
    chk("b2b_stalls", stalls - st0, 0);
    @(posedge clk); #1;

    // Output stall: held result, no acceptance, then resume in order.
    send(model(4'd0, 8'h21, 8'h22));
    out_ready = 1'b0;
    v = model(4'd0, 8'h30, 8'h04);
    op = v.op; a = v.a; b = v.b; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, 8'h43);
      chk("hold_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(v);
    send(model(4'd1, 8'h40, 8'h41));
    drain();

    // Reset four cycles into a MUL aborts it.
    send(model(4'd11, 8'd9, 8'd7));
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    scb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    ov_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) ov_cnt++;
      @(negedge clk);
    end
    chk("abort_no_output", ov_cnt, 0);
    @(posedge clk); #1;
    send('{4'd0, 8'd2, 8'd3, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    drain();

    // Random ops with random downstream back-pressure.
    rnd_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      send(model(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))));
    end
    rnd_mode = 1'b0;
    drain();
    chk("rx_total", rx_count, 20 + 1 + 4 + 3 + 1 + 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, handshaked successor to the team's 8-bit combinational ALU. It adds a registered output, a valid/ready flow control on both sides, status flags, and extra shift and compare ops. It also adds an iterative shift-add multiplier that runs as a multi-cycle FSM. The block sits between the operand/decode stage and writeback, and stalls the upstream stage through in_ready.

Parameters:
WIDTH, 8, operand/result width in bits; must be a power of 2 and at least 4.
SHW, $clog2(WIDTH), shift-amount width (derived, not overridable).

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operands and op valid
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B; low SHW bits are the shift amount for shift ops
op  input  4  operation select
out_valid  output  1  result/flags valid
out_ready  input  1  downstream consumes result this cycle
result  output  WIDTH  registered result
flag_z  output  1  result == 0
flag_n  output  1  result[WIDTH-1]
flag_c  output  1  carry/borrow/multiply-overflow
flag_v  output  1  signed overflow
err  output  1  illegal opcode

Behaviour:
- Reset: while rst is high at an edge, the block loads state=IDLE, out_valid=0, result=0, all flags=0, err=0. No operand is accepted in a cycle where rst=1. Reset aborts an in-flight MUL with no output produced.
- Handshake: in_ready is combinational and equals (state==IDLE) && (!out_valid || out_ready). An operand is accepted when in_valid && in_ready. The output is transferred when out_valid && out_ready.
- While out_valid && !out_ready, result, flags and err are held stable.
- Transfer and a new acceptance in the same cycle are legal and give full throughput of 1 op/cycle for single-cycle ops.
- Single-cycle ops: accepted at edge N, so result, flags and out_valid=1 appear after edge N. Latency is 1.
- Opcodes:
  - 0 ADD a+b
  - 1 SUB a-b
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SHL a<<b[SHW-1:0]
  - 6 SHR logical
  - 7 NOT a
  - 8 SRA arithmetic right
  - 9 SLT signed: result 1 if a<b, else 0, zero-extended
  - 10 SLTU unsigned compare
  - 11 MUL: low WIDTH bits of unsigned a*b
  - 12-15 illegal
- Illegal op: result=0, err=1, flag_z=1, other flags 0, latency 1. err is 0 for every legal op.
- flag_c:
  - ADD: carry-out.
  - SUB: 1 on borrow (a<b unsigned).
  - MUL: 1 if the upper WIDTH bits of the full product are nonzero.
  - Otherwise 0.
- flag_v: signed overflow for ADD/SUB only, else 0. flag_z and flag_n are always derived from the registered result.
- MUL FSM, states IDLE -> BUSY -> IDLE:
  - On acceptance at edge N, the FSM latches a and b, clears a 2*WIDTH accumulator, sets the iteration count to 0 and enters BUSY.
  - Each BUSY cycle processes one multiplier bit (shift-add). After WIDTH iterations the product is written at edge N+WIDTH with out_valid=1, and the FSM returns to IDLE.
  - in_ready=0 throughout BUSY. out_valid=0 throughout BUSY, because the output was empty or draining at acceptance.
- Inputs a, b and op may change freely after acceptance; only latched copies are used.
- No combinational path exists from inputs to result or flags.

Test Plan:
- Reset, then ADD a=8'hFF b=8'h01 -> one cycle later result=8'h00, flag_c=1, flag_z=1, flag_v=0, out_valid=1.
- SUB a=8'h80 b=8'h01 -> result=8'h7F, flag_v=1, flag_c=0. SUB a=8'h01 b=8'h02 -> result=8'hFF, flag_c=1, flag_n=1.
- MUL 8'd13 x 8'd11:
  - Expect result=8'h8F, flag_c=0, out_valid exactly 8 cycles after acceptance, and in_ready=0 during those cycles.
  - MUL 8'h10 x 8'h10 -> result=0, flag_c=1, flag_z=1.
- SRA 8'h90 by b=2 -> 8'hE4. SLT a=8'hFF b=8'h01 -> 8'h01. SLTU on the same operands -> 8'h00. op=4'hC -> result=0, err=1.
- Back-to-back ADDs with out_ready=1 -> one result per cycle. Hold out_ready=0 for 3 cycles -> result held, in_ready=0, no ops lost. Release -> stream resumes in order.
- Assert rst 4 cycles into a MUL -> out_valid stays 0 and in_ready=1 the cycle after rst deasserts. A following ADD 2+3 returns 5.
